// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: branch flush, multi-cycle MDU stall
// and load-use stall. Also keeps saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_RS_addr_i,
  input  logic [4:0]       ID_RT_addr_i,
  input  logic             ID_uses_RT_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_RT_addr_i,
  input  logic             EX_mdu_start_i,
  input  logic             MEM_branch_taken_i,
  input  logic             clear_cnt_i,
  output logic             PC_write_o,
  output logic             IF_ID_write_o,
  output logic             ID_EX_write_o,
  output logic             IF_ID_flush_o,
  output logic             ID_EX_flush_o,
  output logic             EX_MEM_flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             state_o
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } state_e;

  // The start cycle is itself a stall, so the wait state covers LATENCY-2 more.
  localparam logic [3:0]       MDU_LOAD = 4'(MDU_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e           state_q, state_d;
  logic [3:0]       mdu_cnt_q, mdu_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             load_use;
  logic             branch_flush;

  assign load_use = EX_MemRead_i && (EX_RT_addr_i != 5'd0) &&
                    ((EX_RT_addr_i == ID_RS_addr_i) ||
                     (ID_uses_RT_i && (EX_RT_addr_i == ID_RT_addr_i)));

  always_comb begin
    PC_write_o     = 1'b1;
    IF_ID_write_o  = 1'b1;
    ID_EX_write_o  = 1'b1;
    IF_ID_flush_o  = 1'b0;
    ID_EX_flush_o  = 1'b0;
    EX_MEM_flush_o = 1'b0;
    branch_flush   = 1'b0;
    state_d        = state_q;
    mdu_cnt_d      = mdu_cnt_q;

    if (MEM_branch_taken_i) begin
      branch_flush   = 1'b1;
      IF_ID_flush_o  = 1'b1;
      ID_EX_flush_o  = 1'b1;
      EX_MEM_flush_o = 1'b1;
      state_d        = ST_RUN;
      mdu_cnt_d      = 4'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (EX_mdu_start_i) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_write_o  = 1'b0;
            EX_MEM_flush_o = 1'b1;
            mdu_cnt_d      = MDU_LOAD;
            state_d        = ST_MDU_WAIT;
          end else if (load_use) begin
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
            ID_EX_flush_o = 1'b1;
          end
        end
        ST_MDU_WAIT: begin
          if (mdu_cnt_q != 4'd0) begin
            PC_write_o     = 1'b0;
            IF_ID_write_o  = 1'b0;
            ID_EX_write_o  = 1'b0;
            EX_MEM_flush_o = 1'b1;
            mdu_cnt_d      = mdu_cnt_q - 4'd1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d   = ST_RUN;
          mdu_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (clear_cnt_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (!PC_write_o && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (branch_flush && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RUN;
      mdu_cnt_q   <= 4'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mdu_cnt_q   <= mdu_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign state_o     = (state_q == ST_MDU_WAIT);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios, a long
// saturation run and random traffic, all compared against a cycle-age model.
module tb_pipeline_hazard_ctrl;

  localparam int LAT   = 4;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [4:0]       ID_RS_addr_i, ID_RT_addr_i, EX_RT_addr_i;
  logic             ID_uses_RT_i, EX_MemRead_i, EX_mdu_start_i;
  logic             MEM_branch_taken_i, clear_cnt_i;
  logic             PC_write_o, IF_ID_write_o, ID_EX_write_o;
  logic             IF_ID_flush_o, ID_EX_flush_o, EX_MEM_flush_o, state_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mdu_age = 0 when idle, else index of the current cycle within the op.
  int m_age   = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipeline_hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .ID_RS_addr_i       (ID_RS_addr_i),
    .ID_RT_addr_i       (ID_RT_addr_i),
    .ID_uses_RT_i       (ID_uses_RT_i),
    .EX_MemRead_i       (EX_MemRead_i),
    .EX_RT_addr_i       (EX_RT_addr_i),
    .EX_mdu_start_i     (EX_mdu_start_i),
    .MEM_branch_taken_i (MEM_branch_taken_i),
    .clear_cnt_i        (clear_cnt_i),
    .PC_write_o         (PC_write_o),
    .IF_ID_write_o      (IF_ID_write_o),
    .ID_EX_write_o      (ID_EX_write_o),
    .IF_ID_flush_o      (IF_ID_flush_o),
    .ID_EX_flush_o      (ID_EX_flush_o),
    .EX_MEM_flush_o     (EX_MEM_flush_o),
    .stall_cnt_o        (stall_cnt_o),
    .flush_cnt_o        (flush_cnt_o),
    .state_o            (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                        input logic memrd, input logic [4:0] ex_rt, input logic start,
                        input logic br, input logic clr, input logic rst);
    ID_RS_addr_i       = rs;
    ID_RT_addr_i       = rt;
    ID_uses_RT_i       = uses_rt;
    EX_MemRead_i       = memrd;
    EX_RT_addr_i       = ex_rt;
    EX_mdu_start_i     = start;
    MEM_branch_taken_i = br;
    clear_cnt_i        = clr;
    rst_i              = rst;
  endtask

  // Inputs are set at the negedge; check the same-cycle response, then advance.
  task automatic step(input string tag);
    logic pc, ifid, idex, f_ifid, f_idex, f_exmem, lu, stall_mdu;
    #1;
    pc = 1; ifid = 1; idex = 1; f_ifid = 0; f_idex = 0; f_exmem = 0;
    lu = EX_MemRead_i && (EX_RT_addr_i != 0) &&
         ((EX_RT_addr_i == ID_RS_addr_i) || (ID_uses_RT_i && (EX_RT_addr_i == ID_RT_addr_i)));
    stall_mdu = (m_age == 0 && EX_mdu_start_i) || (m_age >= 1 && m_age < LAT - 1);
    if (MEM_branch_taken_i) begin
      f_ifid = 1; f_idex = 1; f_exmem = 1;
    end else if (stall_mdu) begin
      pc = 0; ifid = 0; idex = 0; f_exmem = 1;
    end else if (m_age == 0 && lu) begin
      pc = 0; ifid = 0; f_idex = 1;
    end
    check_eq({tag, ".ctl"},
             32'({PC_write_o, IF_ID_write_o, ID_EX_write_o, IF_ID_flush_o, ID_EX_flush_o, EX_MEM_flush_o, state_o}),
             32'({pc, ifid, idex, f_ifid, f_idex, f_exmem, (m_age != 0)}));
    check_eq({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(m_stall));
    check_eq({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(m_flush));
    if (rst_i) begin
      m_age = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (MEM_branch_taken_i)        m_age = 0;
      else if (m_age == 0)           m_age = EX_mdu_start_i ? 1 : 0;
      else if (m_age < LAT - 1)      m_age = m_age + 1;
      else                           m_age = 0;
      if (clear_cnt_i) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (!pc && m_stall < CMAX)              m_stall++;
        if (MEM_branch_taken_i && m_flush < CMAX) m_flush++;
      end
    end
    @(negedge clk_i);
  endtask

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk_i);
    step("reset0");
    step("reset1");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle");
    $display("txn reset/idle done");

    set_in(5, 1, 0, 1, 5, 0, 0, 0, 0); step("loaduse_rs");
    set_in(0, 1, 0, 0, 5, 0, 0, 0, 0); step("loaduse_after");
    check_eq("loaduse_cnt", 32'(stall_cnt_o), 32'd1);
    $display("txn load-use rs=5 stall_cnt=%0d", stall_cnt_o);

    set_in(0, 0, 1, 1, 0, 0, 0, 0, 0); step("load_r0");
    set_in(2, 7, 1, 1, 7, 0, 0, 0, 0); step("loaduse_rt");
    set_in(2, 7, 0, 1, 7, 0, 0, 0, 0); step("rt_unused");
    $display("txn load r0 / rt cases stall_cnt=%0d", stall_cnt_o);

    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < LAT; i++) step($sformatf("mdu_c%0d", i));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mdu_post");
    check_eq("mdu_cnt", 32'(stall_cnt_o), 32'd5);
    $display("txn mdu op stall_cnt=%0d", stall_cnt_o);

    set_in(5, 0, 0, 1, 5, 0, 1, 0, 0); step("br_loaduse");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("br_post");
    check_eq("br_flush_cnt", 32'(flush_cnt_o), 32'd1);
    $display("txn branch+load-use flush_cnt=%0d", flush_cnt_o);

    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); step("mdu_br0");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mdu_br1");
    set_in(0, 0, 0, 0, 0, 0, 1, 0, 0); step("mdu_br2");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mdu_br3");
    check_eq("mdu_br_state", 32'(state_o), 32'd0);
    $display("txn branch during mdu wait state=%0d", state_o);

    set_in(0, 0, 0, 0, 0, 1, 0, 0, 0); step("mdu_rst0");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mdu_rst1");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1); step("mdu_rst2");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("mdu_rst3");
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_stall", 32'(stall_cnt_o), 32'd0);
    $display("txn reset in mdu wait state=%0d", state_o);

    set_in(3, 0, 0, 1, 3, 0, 0, 0, 0);
    for (int i = 0; i < CMAX + 4; i++) step("sat");
    check_eq("sat_stall", 32'(stall_cnt_o), 32'hFFFF);
    set_in(3, 0, 0, 1, 3, 0, 0, 1, 0); step("clr_override");
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0); step("clr_post");
    check_eq("clr_stall", 32'(stall_cnt_o), 32'd0);
    $display("txn saturate then clear stall_cnt=%0d", stall_cnt_o);

    for (int i = 0; i < 3000; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0),
             ($urandom_range(0, 99) == 0));
      step("rand");
    end
    $display("txn random 3000 cycles stall_cnt=%0d flush_cnt=%0d", stall_cnt_o, flush_cnt_o);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
